// File: rtl/led_pkg.sv
// Shared register map and field positions for the LED PWM driver.
package led_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_BLINK    = 2'd3;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;

  localparam int unsigned BLINK_W = 8;

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM step counter and blink phase generator.
// tick/frame_end are combinational strobes; counters and phase are registered.
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_prescale_wr,
  input  logic                  i_blink_en,
  input  logic [BLINK_W-1:0]    i_blink_period,
  output logic                  o_tick_c,
  output logic                  o_frame_end_c,
  output logic [PWM_W-1:0]      o_pwm_cnt,
  output logic                  o_blink_phase
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [PWM_W-1:0]      r_pwm_cnt;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;
  logic                  w_tick;
  logic                  w_frame_end;

  assign w_tick      = (r_pre_cnt == i_prescale);
  assign w_frame_end = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});

  // A PRESCALE write restarts the current step; the tick itself still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (i_prescale_wr || w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  // Phase toggles after BLINK_PERIOD+1 frames; held on while blink is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (!i_blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_end) begin
      if (r_blink_cnt == i_blink_period) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign o_tick_c      = w_tick;
  assign o_frame_end_c = w_frame_end;
  assign o_pwm_cnt     = r_pwm_cnt;
  assign o_blink_phase = r_blink_phase;

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM/blink driver with Avalon-MM control slave.
// Register file, glitch-free duty shadow and registered LED output stage.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 10,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_req,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  logic                  r_enable;
  logic                  r_blink_en;
  logic [PWM_W-1:0]      r_duty;
  logic [PWM_W-1:0]      r_duty_sh;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [BLINK_W-1:0]    r_blink_period;
  logic [NUM_LEDS-1:0]   r_led_out;

  logic                  w_wr;
  logic                  w_prescale_wr;
  logic                  w_tick;
  logic                  w_frame_end;
  logic [PWM_W-1:0]      w_pwm_cnt;
  logic                  w_blink_phase;
  logic                  w_pwm_on;
  logic                  w_led_gate;
  logic                  w_unused;

  assign w_wr          = chipselect && !write_n;
  assign w_prescale_wr = w_wr && (address == ADDR_PRESCALE);
  assign w_unused      = &{1'b0, writedata, w_tick};

  led_pwm_timebase #(
    .PWM_W      (PWM_W),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_prescale     (r_prescale),
    .i_prescale_wr  (w_prescale_wr),
    .i_blink_en     (r_blink_en),
    .i_blink_period (r_blink_period),
    .o_tick_c       (w_tick),
    .o_frame_end_c  (w_frame_end),
    .o_pwm_cnt      (w_pwm_cnt),
    .o_blink_phase  (w_blink_phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable       <= 1'b1;
      r_blink_en     <= 1'b0;
      r_duty         <= '1;
      r_prescale     <= '0;
      r_blink_period <= BLINK_W'(8'h1F);
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL: begin
          r_enable   <= writedata[CTRL_ENABLE];
          r_blink_en <= writedata[CTRL_BLINK_EN];
        end
        ADDR_DUTY:     r_duty         <= writedata[PWM_W-1:0];
        ADDR_PRESCALE: r_prescale     <= writedata[PRESCALE_W-1:0];
        ADDR_BLINK:    r_blink_period <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  // Duty only changes at frame boundaries so a frame is never cut short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_sh <= '1;
    end else if (w_frame_end) begin
      r_duty_sh <= r_duty;
    end
  end

  always_comb begin
    w_pwm_on = 1'b0;
    if (r_duty_sh == {PWM_W{1'b1}}) begin
      w_pwm_on = 1'b1;
    end else if (r_duty_sh == '0) begin
      w_pwm_on = 1'b0;
    end else begin
      w_pwm_on = (w_pwm_cnt < r_duty_sh);
    end
  end

  assign w_led_gate = r_enable && w_pwm_on && (!r_blink_en || w_blink_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_out <= '0;
    end else begin
      r_led_out <= {NUM_LEDS{w_led_gate}} & led_req;
    end
  end

  assign led_out = r_led_out;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE]   = r_enable;
        readdata[CTRL_BLINK_EN] = r_blink_en;
      end
      ADDR_DUTY:     readdata = 32'(r_duty);
      ADDR_PRESCALE: readdata = 32'(r_prescale);
      ADDR_BLINK:    readdata = 32'({w_blink_phase, r_blink_period});
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed scenarios plus random register traffic,
// checked every cycle against a time-based model of frames and blink periods.
module tb_led_pwm_driver;

  localparam int unsigned NUM_LEDS = 10;
  localparam int FRAME = 256;
  localparam int WAIT_MAX = 3000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NUM_LEDS-1:0] led_req = '0;
  logic [1:0]          address = '0;
  logic                chipselect = 1'b0;
  logic                write_n = 1'b1;
  logic [31:0]         writedata = '0;
  logic [31:0]         readdata;
  logic [NUM_LEDS-1:0] led_out;

  int n_asserts = 0;
  int n_fail = 0;

  // Model: total PWM steps elapsed, cycles into the current step, frames since blink on.
  int m_enable, m_blink_en, m_duty, m_prescale, m_period;
  int m_duty_frame, m_pre, m_ticks, m_frames_bl;
  logic [NUM_LEDS-1:0] m_led;

  led_pwm_driver #(.NUM_LEDS(NUM_LEDS), .PWM_W(8), .PRESCALE_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_req    (led_req),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_enable = 1; m_blink_en = 0; m_duty = 255; m_prescale = 0; m_period = 31;
    m_duty_frame = 255; m_pre = 0; m_ticks = 0; m_frames_bl = 0; m_led = '0;
  endtask

  function automatic int m_phase();
    return (((m_frames_bl / (m_period + 1)) % 2) == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] v;
    v = '0;
    case (a)
      0: begin v[0] = 1'(m_enable); v[1] = 1'(m_blink_en); end
      1: v = 32'(m_duty);
      2: v = 32'(m_prescale);
      default: begin v[7:0] = 8'(m_period); v[8] = 1'(m_phase()); end
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit wr, tick, fe, on;
    int pos;
    wr   = chipselect && !write_n;
    tick = (m_pre == m_prescale);
    pos  = m_ticks % FRAME;
    fe   = tick && (pos == FRAME - 1);
    on   = (m_duty_frame == 255) || (pos < m_duty_frame);
    m_led = (m_enable != 0 && on && (m_blink_en == 0 || m_phase() != 0)) ? led_req : '0;
    m_pre = (tick || (wr && address == 2'd2)) ? 0 : m_pre + 1;
    if (tick) m_ticks++;
    if (fe) m_duty_frame = m_duty;
    if (m_blink_en == 0) m_frames_bl = 0;
    else if (fe) m_frames_bl++;
    if (wr) begin
      case (address)
        2'd0: begin m_enable = int'(writedata[0]); m_blink_en = int'(writedata[1]); end
        2'd1: m_duty = int'(writedata[7:0]);
        2'd2: m_prescale = int'(writedata[15:0]);
        default: m_period = int'(writedata[7:0]);
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led_out", 32'(led_out), 32'(m_led));
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    address = 2'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic wr_nocs(input int a);
    address = 2'(a); writedata = $urandom; chipselect = 1'b0; write_n = 1'b0;
    step();
    write_n = 1'b1;
  endtask

  task automatic rd(input int a);
    address = 2'(a); chipselect = 1'b1; write_n = 1'b1;
    #1;
    check($sformatf("read_addr%0d", a), readdata, m_read(a));
    chipselect = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int duty);
    int n;
    n = 0;
    while (!((m_ticks % FRAME) == 0 && m_pre == 0 && m_duty_frame == duty) && n < WAIT_MAX) begin
      step();
      n++;
    end
    check({tag, "_wait"}, 32'(n < WAIT_MAX), 32'd1);
  endtask

  task automatic count_on(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (led_out == led_req && led_out != '0) highs++;
    end
  endtask

  initial begin
    int highs, n, r, a;
    logic [31:0] d;
    model_reset();

    // Reset behaviour and default pass-through
    led_req = 10'h2A5;
    repeat (3) begin @(posedge clk); #1; check("reset_led", 32'(led_out), 32'd0); end
    rd(0); rd(1);
    reset_n = 1'b1;
    step(); check("passthru_2a5", 32'(led_out), 32'h2A5);
    led_req = 10'h15A;
    step(); check("passthru_15a", 32'(led_out), 32'h15A);
    rd(0); rd(1); rd(2); rd(3);

    // DUTY=128 at PRESCALE=0
    led_req = 10'h3FF;
    wr(1, 32'd128); wr(2, 32'd0);
    wait_frame("duty128", 128);
    count_on(128, highs); check("duty128_high", 32'(highs), 32'd128);
    count_on(128, highs); check("duty128_low", 32'(highs), 32'd0);

    // Mid-frame DUTY change is deferred to the next frame
    wr(1, 32'd200);
    wait_frame("duty200", 200);
    highs = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) wr(1, 32'd64); else step();
      if (led_out == led_req) highs++;
    end
    check("duty200_frame", 32'(highs), 32'd200);
    count_on(FRAME, highs); check("duty64_frame", 32'(highs), 32'd64);

    // PRESCALE=3 stretches the frame to 1024 cycles
    wr(2, 32'd3); wr(1, 32'd2);
    wait_frame("pre3", 2);
    count_on(1024, highs); check("pre3_high", 32'(highs), 32'd8);
    rd(2);
    n = 0;
    while (m_pre != 1 && n < 8) begin step(); n++; end
    wr(2, 32'd3);
    repeat (40) step();

    // Blink at period 1: 512 on / 512 off
    wr(2, 32'd0); wr(1, 32'd255); wr(3, 32'd1); wr(0, 32'd3);
    n = 0;
    while (!(m_frames_bl == 2 && (m_ticks % FRAME) == 0 && m_pre == 0) && n < WAIT_MAX) begin
      step(); n++;
    end
    check("blink_wait", 32'(n < WAIT_MAX), 32'd1);
    count_on(512, highs); check("blink_off_phase", 32'(highs), 32'd0);
    count_on(512, highs); check("blink_on_phase", 32'(highs), 32'd512);
    rd(3); rd(0);
    wr(0, 32'd1);
    step(); check("blink_disable", 32'(led_out), 32'(led_req));

    // Disable, then zero duty
    wr(0, 32'd0);
    step(); check("disable", 32'(led_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      led_req = NUM_LEDS'($urandom) | 10'h001;
      step(); check("disable_hold", 32'(led_out), 32'd0);
    end
    led_req = 10'h3FF;
    wr(0, 32'd1); wr(1, 32'd0);
    wait_frame("duty0", 0);
    count_on(FRAME, highs); check("duty0_frame", 32'(highs), 32'd0);

    // Random register traffic; blink period is only rewritten while blink is off
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) led_req = NUM_LEDS'($urandom);
      if (r == 1) begin
        a = int'($urandom_range(0, 3));
        d = $urandom;
        if (a == 2) d = d & 32'hFFFF_0003;
        if (a == 3) d = d & 32'hFFFF_FF03;
        if (a == 3 && m_blink_en != 0) a = 1;
        wr(a, d);
      end else if (r == 2) begin
        wr_nocs(int'($urandom_range(0, 3)));
      end else begin
        step();
      end
      if (r == 3) rd(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-operation
    led_req = 10'h3FF;
    wr(0, 32'd1); wr(2, 32'd0); wr(1, 32'd255);
    wait_frame("pre_reset", 255);
    step(); check("pre_reset_on", 32'(led_out), 32'h3FF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led_out), 32'd0);
    model_reset();
    rd(0); rd(1); rd(2); rd(3);
    @(posedge clk); #1;
    reset_n = 1'b1;
    led_req = 10'h0F3;
    step(); check("post_reset_passthru", 32'(led_out), 32'h0F3);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
